// File: rtl/gsu_pkg.sv
// gsu_pkg: shared types and constants for the GSU instruction cache.
//   state_e        - cache controller FSM states
//   *_DEF          - default geometry / counter width
//   calc_offs()    - CBR-relative window offset of a fetch address
package gsu_pkg;

    localparam int LINE_BYTES_DEF = 16;
    localparam int NUM_LINES_DEF  = 32;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_FILL,
        ST_BYPASS
    } state_e;

    // The line-offset bits of CBR are ignored, so they are masked here
    // before the 16-bit wrapping subtraction.
    function automatic logic [15:0] calc_offs(input logic [15:0] addr,
                                              input logic [15:0] cbr,
                                              input logic [15:0] line_mask);
        return addr - (cbr & ~line_mask);
    endfunction

endpackage

// File: rtl/gsu_cache_if.sv
// gsu_cache_if: core fetch channel plus backing-memory read channel.
//   fetch_req/fetch_addr  core -> cache, held until fetch_ack
//   fetch_ack/fetch_data  cache -> core, one-cycle pulse with the byte
//   mem_req/mem_addr      cache -> memory, held until mem_ack
//   mem_ack/mem_data      memory -> cache, data valid with the strobe
// Modports: slave = cache side, master = core/memory side.
interface gsu_cache_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport slave (
        input  fetch_req, fetch_addr, mem_ack, mem_data,
        output fetch_ack, fetch_data, mem_req, mem_addr
    );

    modport master (
        output fetch_req, fetch_addr, mem_ack, mem_data,
        input  fetch_ack, fetch_data, mem_req, mem_addr
    );
endinterface

// File: rtl/gsu_cache_ram.sv
// gsu_cache_ram: true dual-port byte RAM, registered reads.
//   clk, rst_n             clock, async active-low reset (read regs only)
//   a_we_i/a_addr_i/a_di_i host port write; a_do_o registered read
//   b_we_i/b_addr_i/b_di_i fetch/fill port write; b_do_o registered read
// On a same-address write collision port A (host) wins.
module gsu_cache_ram #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [7:0]    a_di_i,
    output logic [7:0]    a_do_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [7:0]    b_di_i,
    output logic [7:0]    b_do_o
);
    localparam int DEPTH = 1 << AW;

    logic [7:0] mem_q [DEPTH];

    // Port A is written last so it overrides port B on a collision.
    always_ff @(posedge clk) begin
        if (b_we_i) mem_q[b_addr_i] <= b_di_i;
        if (a_we_i) mem_q[a_addr_i] <= a_di_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_do_o <= 8'h00;
            b_do_o <= 8'h00;
        end else begin
            a_do_o <= mem_q[a_addr_i];
            b_do_o <= mem_q[b_addr_i];
        end
    end
endmodule

// File: rtl/gsu_cache.sv
// gsu_cache: GSU opcode cache with CBR-relative window, line fill from
// backing memory, uncached bypass and an SNES host write/read port.
//   clkin, rst_n        clock, async active-low reset
//   cbr_in, cbr_we      cache base load (also invalidates all lines)
//   flush               invalidate all lines
//   bus (slave)         fetch channel and backing memory channel
//   host_we/addr/di/do  host cache port, host_do one cycle after addr
//   line_valid          per-line valid flags
//   hit_cnt, miss_cnt   statistics counters
// Optional: define GSU_CACHE_STATS_EN to build the saturating counters;
// otherwise both counters are tied to zero.
module gsu_cache
    import gsu_pkg::*;
#(
    parameter  int LINE_BYTES  = LINE_BYTES_DEF,
    parameter  int NUM_LINES   = NUM_LINES_DEF,
    parameter  int CNT_W       = CNT_W_DEF,
    localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES,
    localparam int OW          = $clog2(LINE_BYTES),
    localparam int LW          = $clog2(NUM_LINES),
    localparam int AW          = OW + LW
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic [15:0]          cbr_in,
    input  logic                 cbr_we,
    input  logic                 flush,
    gsu_cache_if.slave           bus,
    input  logic                 host_we,
    input  logic [AW-1:0]        host_addr,
    input  logic [7:0]           host_di,
    output logic [7:0]           host_do,
    output logic [NUM_LINES-1:0] line_valid,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam logic [15:0] LINE_MASK = 16'(LINE_BYTES - 1);

    state_e               state_q, state_d;
    logic [15:0]          cbr_q;
    logic [15:0]          mem_addr_q, mem_addr_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [LW-1:0]        line_q, line_d;    // line being filled
    logic [OW-1:0]        cnt_q, cnt_d;      // fill byte counter
    logic [OW-1:0]        sel_q, sel_d;      // requested byte within line
    logic [7:0]           byte_q, byte_d;    // requested byte captured from fill
    logic                 kill_q, kill_d;    // invalidate seen during fill

    logic [15:0]   offs;
    logic          in_win;
    logic [LW-1:0] f_line;
    logic          inval;
    logic          fill_done;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [7:0]    ram_do_b;

    assign offs   = calc_offs(bus.fetch_addr, cbr_q, LINE_MASK);
    assign in_win = ({1'b0, offs} < 17'(CACHE_BYTES));
    assign f_line = offs[AW-1:OW];
    assign inval  = flush | cbr_we;

    assign bus.mem_req  = (state_q == ST_FILL) || (state_q == ST_BYPASS);
    assign bus.mem_addr = mem_addr_q;
    assign line_valid   = valid_q;

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        line_d         = line_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        byte_d         = byte_q;
        kill_d         = kill_q | inval;
        fill_done      = 1'b0;
        bus.fetch_ack  = 1'b0;
        bus.fetch_data = 8'h00;
        ram_we_b       = 1'b0;
        // Idle: look up the byte now so it is on the read port during HIT.
        ram_addr_b     = offs[AW-1:0];
        unique case (state_q)
            ST_IDLE: begin
                if (bus.fetch_req) begin
                    if (in_win && valid_q[f_line]) begin
                        state_d = ST_HIT;
                    end else if (in_win) begin
                        state_d    = ST_FILL;
                        line_d     = f_line;
                        cnt_d      = '0;
                        sel_d      = offs[OW-1:0];
                        kill_d     = inval;
                        // CBR is line aligned, so the line base in memory is
                        // just the fetch address with the offset bits cleared.
                        mem_addr_d = bus.fetch_addr & ~LINE_MASK;
                    end else begin
                        state_d    = ST_BYPASS;
                        mem_addr_d = bus.fetch_addr;
                    end
                end
            end
            ST_HIT: begin
                bus.fetch_ack  = 1'b1;
                bus.fetch_data = ram_do_b;
                state_d        = ST_IDLE;
            end
            ST_FILL: begin
                ram_addr_b = {line_q, cnt_q};
                if (bus.mem_ack) begin
                    ram_we_b   = 1'b1;
                    mem_addr_d = mem_addr_q + 16'd1;
                    cnt_d      = cnt_q + OW'(1);
                    if (cnt_q == sel_q) byte_d = bus.mem_data;
                    if (&cnt_q) begin
                        bus.fetch_ack  = 1'b1;
                        bus.fetch_data = (cnt_q == sel_q) ? bus.mem_data : byte_q;
                        fill_done      = !kill_q && !inval;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_BYPASS: begin
                if (bus.mem_ack) begin
                    bus.fetch_ack  = 1'b1;
                    bus.fetch_data = bus.mem_data;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Invalidate is applied last so it beats both fill and host validation.
    always_comb begin
        valid_d = valid_q;
        if (fill_done) valid_d[line_q] = 1'b1;
        if (host_we && (&host_addr[OW-1:0])) valid_d[host_addr[AW-1:OW]] = 1'b1;
        if (inval) valid_d = '0;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cbr_q      <= 16'h0000;
            mem_addr_q <= 16'h0000;
            valid_q    <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            byte_q     <= 8'h00;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            byte_q     <= byte_d;
            kill_q     <= kill_d;
            if (cbr_we) cbr_q <= cbr_in & ~LINE_MASK;
        end
    end

`ifdef GSU_CACHE_STATS_EN
    logic [CNT_W-1:0] hit_q, miss_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (inval) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_HIT && hit_q != '1)
                hit_q <= hit_q + CNT_W'(1);
            if (state_q == ST_IDLE && state_d == ST_FILL && miss_q != '1)
                miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    gsu_cache_ram #(.AW(AW)) u_ram (
        .clk      (clkin),
        .rst_n    (rst_n),
        .a_we_i   (host_we),
        .a_addr_i (host_addr),
        .a_di_i   (host_di),
        .a_do_o   (host_do),
        .b_we_i   (ram_we_b),
        .b_addr_i (ram_addr_b),
        .b_di_i   (bus.mem_data),
        .b_do_o   (ram_do_b)
    );
endmodule

// File: tb/tb_gsu_cache.sv
// tb_gsu_cache: directed scenarios plus randomized fetch/host/flush/CBR
// traffic against a byte-array reference model of the cache.
module tb_gsu_cache;
    localparam int LB       = 16;
    localparam int NL       = 32;
    localparam int CB       = LB * NL;
    localparam int AW       = 9;
    localparam int TB_CNT_W = 4;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;
    localparam logic [15:0] LMASK = 16'(LB - 1);
`ifdef GSU_CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clkin = 1'b0;
    logic                rst_n = 1'b0;
    logic [15:0]         cbr_in = 16'h0000;
    logic                cbr_we = 1'b0;
    logic                flush = 1'b0;
    logic                host_we = 1'b0;
    logic [AW-1:0]       host_addr = '0;
    logic [7:0]          host_di = 8'h00;
    logic [7:0]          host_do;
    logic [NL-1:0]       line_valid;
    logic [TB_CNT_W-1:0] hit_cnt, miss_cnt;

    gsu_cache_if bus_if ();

    gsu_cache #(.LINE_BYTES(LB), .NUM_LINES(NL), .CNT_W(TB_CNT_W)) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .cbr_in     (cbr_in),
        .cbr_we     (cbr_we),
        .flush      (flush),
        .bus        (bus_if),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_di    (host_di),
        .host_do    (host_do),
        .line_valid (line_valid),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ram_m   [CB];
    bit          valid_m [NL];
    logic [15:0] cbr_m = 16'h0000;
    int          hit_m = 0, miss_m = 0;
    bit          killed = 1'b0;
    logic [15:0] memq [$];   // every address the memory acknowledged

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [NL-1:0] valid_vec();
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = valid_m[i];
        return v;
    endfunction

    function automatic void model_inval();
        for (int i = 0; i < NL; i++) valid_m[i] = 1'b0;
        hit_m  = 0;
        miss_m = 0;
        killed = 1'b1;
    endfunction

    // ---------------- backing memory responder ----------------
    initial begin
        int wait_c;
        wait_c = 0;
        bus_if.mem_ack  = 1'b0;
        bus_if.mem_data = 8'h00;
        forever begin
            @(posedge clkin); #1;
            bus_if.mem_ack = 1'b0;
            if (bus_if.mem_req === 1'b1) begin
                if (wait_c == 0) begin
                    bus_if.mem_ack  = 1'b1;
                    bus_if.mem_data = mem_byte(bus_if.mem_addr);
                    memq.push_back(bus_if.mem_addr);
                    wait_c = $urandom_range(0, 2);
                end else begin
                    wait_c--;
                end
            end
        end
    end

    // ---------------- stimulus tasks (start/end at posedge+1) ----------------
    task automatic tick();
        @(posedge clkin); #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_valid"}, line_valid, valid_vec());
        chk({tag, "_hits"}, hit_cnt, STATS ? hit_m : 0);
        chk({tag, "_miss"}, miss_cnt, STATS ? miss_m : 0);
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_di = d;
        ram_m[a] = d;
        if (a[3:0] == 4'hF) valid_m[a[AW-1:4]] = 1'b1;
        tick();
        host_we = 1'b0;
        chk("host_wr_valid", line_valid, valid_vec());
    endtask

    task automatic host_rd(input logic [AW-1:0] a);
        host_addr = a;
        tick();
        chk("host_do", host_do, ram_m[a]);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_inval();
        tick();
        flush = 1'b0;
    endtask

    task automatic do_cbr(input logic [15:0] v);
        cbr_in = v; cbr_we = 1'b1;
        cbr_m = v & ~LMASK;
        model_inval();
        tick();
        cbr_we = 1'b0;
        chk_state("cbr");
    endtask

    // kind: 0 = hit, 1 = fill, 2 = bypass, derived from the window rules.
    task automatic do_fetch(input logic [15:0] a);
        logic [15:0] offs, base;
        logic [7:0]  exp_d;
        int kind, line, q0;
        bit got, ok;
        offs = a - cbr_m;
        base = a & ~LMASK;
        line = int'(offs) / LB;
        q0 = memq.size();
        killed = 1'b0;
        if (offs < 16'(CB)) kind = valid_m[line] ? 0 : 1;
        else kind = 2;
        if (kind == 0) begin
            exp_d = ram_m[offs[AW-1:0]];
            if (hit_m < MAXC) hit_m++;
        end else begin
            exp_d = mem_byte(a);
            if (kind == 1 && miss_m < MAXC) miss_m++;
        end
        bus_if.fetch_req = 1'b1; bus_if.fetch_addr = a;
        got = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            @(negedge clkin);
            if (bus_if.fetch_ack === 1'b1) begin
                got = 1'b1;
                chk("fetch_data", bus_if.fetch_data, exp_d);
                if (kind == 0) begin
                    chk("hit_latency", cyc, 1);
                    chk("hit_no_mem", memq.size() - q0, 0);
                end else begin
                    chk("ack_with_mem_ack", bus_if.mem_ack, 1);
                    chk("mem_req_count", memq.size() - q0, kind == 1 ? LB : 1);
                end
            end
            tick();
        end
        bus_if.fetch_req = 1'b0;
        if (!got) chk("fetch_timeout", 0, 1);
        if (kind == 1) begin
            ok = (memq.size() - q0 == LB);
            for (int i = 0; i < LB && ok; i++)
                if (memq[q0 + i] !== 16'(int'(base) + i)) ok = 1'b0;
            chk("fill_addrs", ok, 1);
            for (int i = 0; i < LB; i++)
                ram_m[line * LB + i] = mem_byte(16'(int'(base) + i));
            if (!killed) valid_m[line] = 1'b1;
        end else if (kind == 2 && memq.size() > q0) begin
            chk("bypass_addr", memq[q0], a);
        end
        chk_state("fetch");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int q0, n, acks;
        logic [15:0] a;
        bus_if.fetch_req  = 1'b0;
        bus_if.fetch_addr = 16'h0000;
        for (int i = 0; i < NL; i++) valid_m[i] = 1'b0;

        repeat (2) @(posedge clkin);
        #1;
        chk("rst_fetch_ack", bus_if.fetch_ack, 0);
        chk("rst_fetch_data", bus_if.fetch_data, 0);
        chk("rst_mem_req", bus_if.mem_req, 0);
        chk("rst_mem_addr", bus_if.mem_addr, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_host_do", host_do, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Give every RAM byte a known value, then drop the valids it created.
        for (int i = 0; i < CB; i++) host_wr(AW'(i), 8'($urandom));
        do_flush();
        chk("init_flushed", line_valid, 0);

        // Host-loaded line hit.
        for (int i = 0; i < 16; i++) host_wr(AW'(i), 8'(i));
        do_fetch(16'h0005);
        chk("hit_line0_valid", line_valid[0], 1);

        // Miss fills line 2.
        do_fetch(16'h0023);
        chk("fill_line2_valid", line_valid[2], 1);

        // Flush during the 5th fill byte: ack still delivered, line left invalid.
        q0 = memq.size();
        fork
            do_fetch(16'h0047);
            begin
                n = 0;
                while (memq.size() < q0 + 5 && n < 300) begin @(negedge clkin); n++; end
                if (n < 300) begin
                    flush = 1'b1;
                    model_inval();
                    @(posedge clkin); #1;
                    flush = 1'b0;
                end
            end
        join
        chk("flushed_fill_invalid", line_valid[4], 0);
        do_fetch(16'h0047);

        // Host write and fill write to the same byte in the same cycle.
        q0 = memq.size();
        fork
            do_fetch(16'h0065);
            begin
                n = 0;
                while (memq.size() < q0 + 4 && n < 300) begin @(negedge clkin); n++; end
                if (n < 300) begin
                    host_we = 1'b1; host_addr = 9'h063; host_di = 8'hA5;
                    @(posedge clkin); #1;
                    host_we = 1'b0;
                end
            end
        join
        ram_m[9'h063] = 8'hA5;
        host_rd(9'h063);
        host_rd(9'h064);
        host_rd(9'h065);

        // Host validating write coinciding with flush: flush wins.
        host_we = 1'b1; host_addr = 9'h0AF; host_di = 8'h77; flush = 1'b1;
        ram_m[9'h0AF] = 8'h77;
        model_inval();
        tick();
        host_we = 1'b0; flush = 1'b0;
        chk("flush_beats_host_valid", line_valid, 0);

        // Out-of-window fetch bypasses the cache.
        do_cbr(16'h1000);
        host_wr(9'h03F, 8'h12);
        do_fetch(16'h0800);

        // Window wrapping around 0000 and counter saturation.
        do_cbr(16'hFF00);
        do_fetch(16'h0010);
        for (int i = 0; i < 20; i++) do_fetch(16'h0012);
        chk("hit_saturated", hit_cnt, STATS ? MAXC : 0);
        do_cbr(16'hFFF7);
        chk("cbr_clears_hits", hit_cnt, 0);
        do_fetch(16'hFFF3);
        do_fetch(16'hFFFA);

        // Reset in the middle of a fill.
        do_flush();
        a = cbr_m + 16'h0105;
        q0 = memq.size();
        bus_if.fetch_req = 1'b1; bus_if.fetch_addr = a;
        n = 0;
        while (memq.size() < q0 + 3 && n < 200) begin tick(); n++; end
        chk("rst_fill_started", (memq.size() >= q0 + 3), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fetch_ack", bus_if.fetch_ack, 0);
        chk("mid_rst_fetch_data", bus_if.fetch_data, 0);
        chk("mid_rst_mem_req", bus_if.mem_req, 0);
        chk("mid_rst_mem_addr", bus_if.mem_addr, 0);
        chk("mid_rst_line_valid", line_valid, 0);
        chk("mid_rst_host_do", host_do, 0);
        chk("mid_rst_hit_cnt", hit_cnt, 0);
        chk("mid_rst_miss_cnt", miss_cnt, 0);
        bus_if.fetch_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cbr_m = 16'h0000;
        model_inval();
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkin);
            if (bus_if.fetch_ack !== 1'b0) acks++;
        end
        tick();
        chk("no_ack_after_reset", acks, 0);
        // The abandoned fill left part of cache line 0x10 in an unknown mix.
        for (int i = 0; i < LB; i++) host_wr(AW'(16'h0100 + 16'(i)), 8'($urandom));
        do_flush();

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 10) begin
                if ($urandom_range(0, 3) != 0) a = cbr_m + 16'($urandom_range(0, CB - 1));
                else a = 16'($urandom);
                do_fetch(a);
            end else if (op < 15) begin
                host_wr(AW'($urandom), 8'($urandom));
            end else if (op < 18) begin
                host_rd(AW'($urandom));
            end else if (op == 18) begin
                do_flush();
            end else begin
                do_cbr(16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gsu_cache.md
GSU_CACHE -- requirements
Module: gsu_cache

Interface
REQ-001 Parameter LINE_BYTES, default 16, bytes per cache line, power of two from 4 to 64.
REQ-002 Parameter NUM_LINES, default 32, number of lines, power of two from 2 to 128; CACHE_BYTES = LINE_BYTES*NUM_LINES.
REQ-003 Parameter CNT_W, default 16, width of the statistics counters.
REQ-004 clkin  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 cbr_in  in  16  cache base address; bits [log2(LINE_BYTES)-1:0] are ignored and treated as 0.
REQ-007 cbr_we  in  1  loads CBR from cbr_in and invalidates all lines.
REQ-008 flush  in  1  invalidates all lines without changing CBR.
REQ-009 fetch_req, fetch_addr  in  1, 16  core opcode fetch request and its address; held until fetch_ack.
REQ-010 fetch_ack, fetch_data  out  1, 8  one-cycle acknowledge pulse and the returned byte.
REQ-011 mem_req, mem_addr  out  1, 16  backing ROM/RAM byte read request and its address; held until mem_ack.
REQ-012 mem_ack, mem_data  in  1, 8  read completion strobe; mem_data is valid in the same cycle.
REQ-013 host_we, host_addr, host_di  in  1, log2(CACHE_BYTES), 8  SNES host cache write port; the address is CBR-relative and wraps modulo CACHE_BYTES.
REQ-014 host_do  out  8  host read data, one cycle after host_addr.
REQ-015 line_valid  out  NUM_LINES  per-line valid flags.
REQ-016 hit_cnt, miss_cnt  out  CNT_W each  statistics counters.

Function
REQ-017 Window: offs = fetch_addr - CBR (16-bit wrap); the fetch is in-window when offs < CACHE_BYTES; line index = offs / LINE_BYTES.
REQ-018 The FSM SHALL have four states: IDLE, HIT, FILL and BYPASS.
REQ-019 In IDLE with fetch_req asserted: go to HIT if the fetch is in-window and the line is valid, to FILL if it is in-window and the line is invalid, otherwise to BYPASS.
REQ-020 HIT: fetch_ack and fetch_data are asserted the cycle after the request is accepted, then the FSM returns to IDLE; back-to-back hits therefore complete one fetch every 2 cycles.
REQ-021 FILL: read LINE_BYTES bytes in ascending order starting at the line base; exactly one mem_req is outstanding at a time, and mem_addr advances on each mem_ack.
REQ-022 At the final mem_ack of a fill, the line is set valid and fetch_ack is asserted with the requested byte, captured from the fill, in the same cycle; the FSM then returns to IDLE.
REQ-023 BYPASS: one mem_req is issued at fetch_addr; fetch_ack is asserted with mem_data on the mem_ack cycle; nothing is cached.
REQ-024 A host write stores host_di; a host write to line offset LINE_BYTES-1 sets that line valid, and other offsets leave the valid flag unchanged.
REQ-025 If a host write and a fill write target the same byte in the same cycle, the host data is stored.
REQ-026 A flush or cbr_we that occurs during FILL lets the fill complete and deliver its byte, but the line is left invalid.
REQ-027 If flush or cbr_we coincides with a host write that would set a line valid, the invalidate takes priority.
REQ-028 Window offsets wrap modulo 2^16 (for example CBR=FF00 with fetch_addr=0010 gives offs 0110); mem_addr wraps at FFFF.

Reset
REQ-029 While rst_n is low: FSM=IDLE, CBR=0000, line_valid=0, fetch_ack=0, fetch_data=00, mem_req=0, mem_addr=0000, host_do=00, hit_cnt=0, miss_cnt=0; cache RAM contents are not reset.
REQ-030 If rst_n is asserted mid-fill, the fill is abandoned and no ack is produced after reset is released.

Configuration
REQ-031 With GSU_CACHE_STATS_EN defined: hit_cnt increments on each HIT entry and miss_cnt on each FILL entry; both saturate at all-ones and are cleared by flush or cbr_we.
REQ-032 Without GSU_CACHE_STATS_EN: hit_cnt and miss_cnt are tied to 0 and no counter logic exists.

Structure
REQ-033 Package gsu_pkg SHALL hold the FSM state enum, the default LINE_BYTES/NUM_LINES/CNT_W constants and the offset-calculation function.
REQ-034 Sub-module gsu_cache_ram: true dual-port CACHE_BYTES x 8 RAM with registered reads; port A serves the host, port B serves fetch and fill.

Verification
REQ-035 CBR=0000; host writes 00..0F to addresses 000..00F; fetch 0005 -> line_valid[0]=1, ack 1 cycle later, data 05, hit_cnt=1.
REQ-036 Fetch 0023 with line 2 invalid -> 16 mem_req at 0020..002F; ack on the 16th mem_ack with mem_data from 0023; miss_cnt=1; line_valid[2]=1.
REQ-037 CBR=1000; fetch 0800 -> single mem_req at 0800, ack on mem_ack, line_valid unchanged.
REQ-038 flush pulsed during the 5th fill byte -> fill completes and acks, line stays invalid; a repeat fetch refills the line.
REQ-039 rst_n dropped during FILL -> all outputs return to reset values immediately; no fetch_ack after release.
REQ-040 With GSU_CACHE_STATS_EN and CNT_W=4: 20 hits -> hit_cnt=F; cbr_we -> 0.
